// File: rtl/upstream_frame_gen.sv
// Test-frame generator for the Aurora AXIS TX port: header word plus counting payload per frame.
// Latency: header valid one cycle after enable is sampled; one word per cycle with tx_tready high.
// Backpressure: tx_tready low holds the current word stable; tx_tvalid never drops without a handshake.
module upstream_frame_gen #(
    parameter int LEN_W = 8,
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [GAP_W-1:0] gap_len,
    output logic [127:0]     tx_tdata,
    output logic [15:0]      tx_tkeep,
    output logic             tx_tvalid,
    output logic             tx_tlast,
    input  logic             tx_tready,
    output logic [31:0]      frame_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] len_l, len_n, k, k_n;
    logic [GAP_W-1:0] gap_l, gap_n, gcnt, gcnt_n;
    logic [31:0]      seq, seq_n, cnt_n;
    logic [127:0]     tdata_n;
    logic             tvalid_n, tlast_n;
    logic             hs, done, start;

    assign hs = tx_tvalid && tx_tready;

    always_comb begin
        state_n = state;
        len_n   = len_l;
        gap_n   = gap_l;
        k_n     = k;
        gcnt_n  = gcnt;
        seq_n   = seq;
        cnt_n   = frame_cnt;
        done    = 1'b0;
        start   = 1'b0;
        case (state)
            IDLE: start = enable;
            HDR: begin
                if (hs) begin
                    if (len_l == '0) begin
                        done = 1'b1;
                    end else begin
                        k_n     = LEN_W'(1);
                        state_n = PAY;
                    end
                end
            end
            PAY: begin
                if (hs) begin
                    k_n = k + 1'b1;
                    if (k == len_l) done = 1'b1;
                end
            end
            GAP: begin
                gcnt_n = gcnt - 1'b1;
                if (gcnt == GAP_W'(1)) begin
                    if (enable) start = 1'b1;
                    else        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (done) begin
            seq_n = seq + 32'd1;
            cnt_n = frame_cnt + 32'd1;
            if (gap_l != '0) begin
                state_n = GAP;
                gcnt_n  = gap_l;
            end else if (enable) begin
                start = 1'b1;
            end else begin
                state_n = IDLE;
            end
        end

        // Frame parameters are captured only here, so mid-frame input changes wait for the next frame.
        if (start) begin
            len_n   = frame_len;
            gap_n   = gap_len;
            k_n     = '0;
            state_n = HDR;
        end
    end

    // Outputs are built from next-state values so they can be registered without adding a cycle.
    always_comb begin
        tvalid_n = (state_n == HDR) || (state_n == PAY);
        tlast_n  = 1'b0;
        tdata_n  = '0;
        if (state_n == HDR) begin
            tdata_n = {32'hA5A5_5A5A, seq_n, 16'h0, 16'(len_n), 32'h0};
            tlast_n = (len_n == '0);
        end else if (state_n == PAY) begin
            tdata_n = {4{seq_n[15:0], 16'(k_n)}};
            tlast_n = (k_n == len_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_l     <= '0;
            gap_l     <= '0;
            k         <= '0;
            gcnt      <= '0;
            seq       <= '0;
            frame_cnt <= '0;
            tx_tdata  <= '0;
            tx_tkeep  <= '0;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            len_l     <= len_n;
            gap_l     <= gap_n;
            k         <= k_n;
            gcnt      <= gcnt_n;
            seq       <= seq_n;
            frame_cnt <= cnt_n;
            tx_tdata  <= tdata_n;
            tx_tkeep  <= tvalid_n ? 16'hFFFF : 16'h0000;
            tx_tvalid <= tvalid_n;
            tx_tlast  <= tlast_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule
